demux_stream_router: RTL and testbench

- Parametrised successor of the two-output combinational demultiplexer.
- Routes a stream of DATA_W-bit words from one producer to one of N_OUT consumers, selected per word, or to all consumers in broadcast mode.
- Each output has its own DEPTH-entry FIFO, so a stalled consumer blocks only words addressed to it.
- Sits between the command decoder and the per-unit command queues (sprite/background/robot-control units).

---
 rtl/demux_stream_router_if.sv | 31 +++
 rtl/demux_stream_router.sv | 136 +++++++++++++
 tb/tb_demux_stream_router.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_router_if.sv
// Stream bundle between the command decoder and the per-unit command queues:
// one producer-side word channel in, N_OUT consumer-side word channels out.
interface demux_stream_router_if #(
  parameter int DATA_W = 32,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic [DATA_W-1:0]         in_data;
  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT-1:0]          out_ready;
  logic [N_OUT*DATA_W-1:0]   out_data;
  logic [N_OUT*LVL_W-1:0]    out_level;

  // Producer and consumers drive the word-side inputs; the router answers.
  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_level
  );

  modport slave (
    input  in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data, out_level
  );
endinterface

// File: rtl/demux_stream_router.sv
// Routes each input word to one of N_OUT per-channel FWFT FIFOs (or to all of
// them in broadcast); words addressed to a non-existent channel are counted and dropped.
module demux_stream_router #(
  parameter int DATA_W = 32,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  demux_stream_router_if.slave  bus,
  output logic                  drop_pulse,
  output logic [CNT_W-1:0]      drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q    [N_OUT][DEPTH];
  logic [DATA_W-1:0] mem_d    [N_OUT][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [N_OUT];
  logic [PTR_W-1:0]  wr_ptr_d [N_OUT];
  logic [PTR_W-1:0]  rd_ptr_q [N_OUT];
  logic [PTR_W-1:0]  rd_ptr_d [N_OUT];
  logic [LVL_W-1:0]  count_q  [N_OUT];
  logic [LVL_W-1:0]  count_d  [N_OUT];

  logic              drop_pulse_q;
  logic              drop_pulse_d;
  logic [CNT_W-1:0]  drop_count_q;
  logic [CNT_W-1:0]  drop_count_d;

  logic [N_OUT-1:0]  full;
  logic [N_OUT-1:0]  empty;
  logic [N_OUT-1:0]  sel_hit;
  logic [N_OUT-1:0]  push;
  logic [N_OUT-1:0]  pop;
  logic              in_ready;
  logic              accept;
  logic              drop;

  always_comb begin
    full    = '0;
    empty   = '0;
    sel_hit = '0;
    for (int i = 0; i < N_OUT; i++) begin
      full[i]    = (count_q[i] == LVL_W'(DEPTH));
      empty[i]   = (count_q[i] == '0);
      sel_hit[i] = (bus.in_sel == SEL_W'(i));
    end
  end

  // An out-of-range selector matches no channel and is always sunk.
  always_comb begin
    in_ready = 1'b1;
    if (bus.in_bcast) begin
      in_ready = ~|full;
    end else if (|sel_hit) begin
      in_ready = ~|(full & sel_hit);
    end
  end

  always_comb begin
    accept = bus.in_valid && in_ready;
    push   = '0;
    if (accept) begin
      push = bus.in_bcast ? {N_OUT{1'b1}} : sel_hit;
    end
    drop = accept && !bus.in_bcast && !(|sel_hit);
    pop  = ~empty & bus.out_ready;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.in_data;
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
      count_d[i] = count_q[i] + LVL_W'(push[i]) - LVL_W'(pop[i]);
    end
  end

  always_comb begin
    drop_pulse_d = drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Head word is masked to zero on empty channels so consumers never see stale data.
  always_comb begin
    bus.out_valid = ~empty;
    bus.out_data  = '0;
    bus.out_level = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (!empty[i]) begin
        bus.out_data[i*DATA_W +: DATA_W] = mem_q[i][rd_ptr_q[i]];
      end
      bus.out_level[i*LVL_W +: LVL_W] = count_q[i];
    end
  end

  assign bus.in_ready = in_ready;
  assign drop_pulse   = drop_pulse_q;
  assign drop_count   = drop_count_q;
endmodule

// File: tb/tb_demux_stream_router.sv
// Directed bench: a default 4-channel router plus a 3-channel, 2-bit-counter
// router for the invalid-index drop path.
module tb_demux_stream_router;
  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  demux_stream_router_if #(.DATA_W(32), .N_OUT(4), .SEL_W(2), .DEPTH(4)) bus4 ();
  demux_stream_router_if #(.DATA_W(32), .N_OUT(3), .SEL_W(2), .DEPTH(4)) bus3 ();

  logic       drop_pulse4;
  logic [7:0] drop_count4;
  logic       drop_pulse3;
  logic [1:0] drop_count3;

  demux_stream_router #(.DATA_W(32), .N_OUT(4), .SEL_W(2), .DEPTH(4), .CNT_W(8)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus4),
    .drop_pulse (drop_pulse4),
    .drop_count (drop_count4)
  );

  demux_stream_router #(.DATA_W(32), .N_OUT(3), .SEL_W(2), .DEPTH(4), .CNT_W(2)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus3),
    .drop_pulse (drop_pulse3),
    .drop_count (drop_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus4.in_valid  = 1'b0;
    bus4.in_sel    = 2'd0;
    bus4.in_bcast  = 1'b0;
    bus4.in_data   = 32'h0;
    bus4.out_ready = 4'b0000;
    bus3.in_valid  = 1'b0;
    bus3.in_sel    = 2'd0;
    bus3.in_bcast  = 1'b0;
    bus3.in_data   = 32'h0;
    bus3.out_ready = 3'b000;
  endtask

  task automatic push4(input logic [1:0] sel, input logic [31:0] data);
    bus4.in_valid = 1'b1;
    bus4.in_bcast = 1'b0;
    bus4.in_sel   = sel;
    bus4.in_data  = data;
    step();
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL reset_out_valid: got %b expected %b", bus4.out_valid, 4'b0000); n_fail++;
    end
    n_checks++;
    if (bus4.out_level !== 12'h000) begin
      $display("[TB] FAIL reset_out_level: got %h expected %h", bus4.out_level, 12'h000); n_fail++;
    end
    n_checks++;
    if (bus4.out_data !== 128'h0) begin
      $display("[TB] FAIL reset_out_data: got %h expected 0", bus4.out_data); n_fail++;
    end
    n_checks++;
    if (drop_pulse3 !== 1'b0 || drop_count3 !== 2'd0) begin
      $display("[TB] FAIL reset_drop: got pulse %b count %0d expected 0 0", drop_pulse3, drop_count3); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_unicast;
    push4(2'd2, 32'hA5A5_0001);
    if (bus4.out_valid !== 4'b0100) begin
      $display("[TB] FAIL unicast_valid: got %b expected %b", bus4.out_valid, 4'b0100); n_fail++;
    end
    n_checks++;
    if (bus4.out_data[64 +: 32] !== 32'hA5A5_0001) begin
      $display("[TB] FAIL unicast_data: got %h expected %h", bus4.out_data[64 +: 32], 32'hA5A5_0001); n_fail++;
    end
    n_checks++;
    if (bus4.out_level !== 12'b000_001_000_000) begin
      $display("[TB] FAIL unicast_level: got %b expected %b", bus4.out_level, 12'b000_001_000_000); n_fail++;
    end
    n_checks++;
    if (bus4.out_data[31:0] !== 32'h0 || bus4.out_data[63:32] !== 32'h0 || bus4.out_data[127:96] !== 32'h0) begin
      $display("[TB] FAIL unicast_other_data: got %h expected zero outside channel 2", bus4.out_data); n_fail++;
    end
    n_checks++;
    bus4.out_ready = 4'b0100;
    step();
    bus4.out_ready = 4'b0000;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL unicast_drain: got %b expected %b", bus4.out_valid, 4'b0000); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 4; k++) push4(2'd1, 32'h0000_1000 + k);
    bus4.in_valid = 1'b1;
    bus4.in_sel   = 2'd1;
    bus4.in_data  = 32'h0000_1111;
    #1;
    if (bus4.in_ready !== 1'b0) begin
      $display("[TB] FAIL bp_ready_full: got %b expected 0", bus4.in_ready); n_fail++;
    end
    n_checks++;
    bus4.in_sel  = 2'd0;
    bus4.in_data = 32'h0000_2000;
    #1;
    if (bus4.in_ready !== 1'b1) begin
      $display("[TB] FAIL bp_ready_other: got %b expected 1", bus4.in_ready); n_fail++;
    end
    n_checks++;
    step();
    bus4.in_valid = 1'b0;
    if (bus4.out_data[31:0] !== 32'h0000_2000 || bus4.out_level !== 12'b000_000_100_001) begin
      $display("[TB] FAIL bp_side_accept: got data %h level %b expected %h %b",
               bus4.out_data[31:0], bus4.out_level, 32'h0000_2000, 12'b000_000_100_001); n_fail++;
    end
    n_checks++;
    bus4.in_sel    = 2'd1;
    bus4.out_ready = 4'b0011;
    #1;
    if (bus4.in_ready !== 1'b0) begin
      $display("[TB] FAIL bp_ready_pop_cycle: got %b expected 0", bus4.in_ready); n_fail++;
    end
    n_checks++;
    for (int k = 0; k < 4; k++) begin
      if (bus4.out_data[32 +: 32] !== 32'h0000_1000 + k) begin
        $display("[TB] FAIL bp_order_%0d: got %h expected %h", k, bus4.out_data[32 +: 32], 32'h0000_1000 + k); n_fail++;
      end
      n_checks++;
      step();
      if (k == 0) begin
        if (bus4.in_ready !== 1'b1) begin
          $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", bus4.in_ready); n_fail++;
        end
        n_checks++;
      end
    end
    bus4.out_ready = 4'b0000;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL bp_drained: got %b expected %b", bus4.out_valid, 4'b0000); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_broadcast;
    for (int k = 0; k < 4; k++) push4(2'd3, 32'h0000_3000 + k);
    bus4.in_valid = 1'b1;
    bus4.in_bcast = 1'b1;
    bus4.in_sel   = 2'd0;
    bus4.in_data  = 32'h0000_BEEF;
    #1;
    if (bus4.in_ready !== 1'b0) begin
      $display("[TB] FAIL bcast_blocked_ready: got %b expected 0", bus4.in_ready); n_fail++;
    end
    n_checks++;
    step();
    if (bus4.out_level !== 12'b100_000_000_000) begin
      $display("[TB] FAIL bcast_blocked_level: got %b expected %b", bus4.out_level, 12'b100_000_000_000); n_fail++;
    end
    n_checks++;
    bus4.out_ready = 4'b1000;
    step();
    bus4.out_ready = 4'b0000;
    #1;
    if (bus4.in_ready !== 1'b1) begin
      $display("[TB] FAIL bcast_ready_after_drain: got %b expected 1", bus4.in_ready); n_fail++;
    end
    n_checks++;
    step();
    bus4.in_valid = 1'b0;
    bus4.in_bcast = 1'b0;
    if (bus4.out_level !== 12'b100_001_001_001) begin
      $display("[TB] FAIL bcast_level: got %b expected %b", bus4.out_level, 12'b100_001_001_001); n_fail++;
    end
    n_checks++;
    if (bus4.out_data[31:0] !== 32'h0000_BEEF || bus4.out_data[95:64] !== 32'h0000_BEEF
        || bus4.out_data[127:96] !== 32'h0000_3001) begin
      $display("[TB] FAIL bcast_data: got %h expected BEEF on ch0-2, 3001 on ch3", bus4.out_data); n_fail++;
    end
    n_checks++;
    bus4.out_ready = 4'b1111;
    repeat (4) step();
    bus4.out_ready = 4'b0000;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL bcast_drained: got %b expected %b", bus4.out_valid, 4'b0000); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_drop;
    bus3.in_valid = 1'b1;
    bus3.in_sel   = 2'd3;
    bus3.in_data  = 32'hDEAD_0000;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (bus3.in_ready !== 1'b1) begin
        $display("[TB] FAIL drop_ready_%0d: got %b expected 1", k, bus3.in_ready); n_fail++;
      end
      n_checks++;
      step();
      if (drop_pulse3 !== 1'b1 || drop_count3 !== ((k > 3) ? 2'd3 : 2'(k))) begin
        $display("[TB] FAIL drop_count_%0d: got pulse %b count %0d expected 1 %0d",
                 k, drop_pulse3, drop_count3, (k > 3) ? 3 : k); n_fail++;
      end
      n_checks++;
      if (k == 3) begin
        bus3.in_valid = 1'b0;
        step();
        if (drop_pulse3 !== 1'b0 || drop_count3 !== 2'd3 || bus3.out_valid !== 3'b000) begin
          $display("[TB] FAIL drop_idle: got pulse %b count %0d valid %b expected 0 3 000",
                   drop_pulse3, drop_count3, bus3.out_valid); n_fail++;
        end
        n_checks++;
        bus3.in_valid = 1'b1;
      end
    end
    bus3.in_valid = 1'b0;
    step();
    if (drop_pulse3 !== 1'b0 || bus3.out_valid !== 3'b000) begin
      $display("[TB] FAIL drop_end: got pulse %b valid %b expected 0 000", drop_pulse3, bus3.out_valid); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back;
    push4(2'd0, 32'h0000_5000);
    push4(2'd0, 32'h0000_5001);
    bus4.in_valid  = 1'b1;
    bus4.in_sel    = 2'd0;
    bus4.out_ready = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      bus4.in_data = 32'h0000_5002 + k;
      #1;
      if (bus4.out_data[31:0] !== 32'h0000_5000 + k || bus4.out_level[2:0] !== 3'd2 || bus4.in_ready !== 1'b1) begin
        $display("[TB] FAIL b2b_%0d: got data %h level %0d ready %b expected %h 2 1",
                 k, bus4.out_data[31:0], bus4.out_level[2:0], bus4.in_ready, 32'h0000_5000 + k); n_fail++;
      end
      n_checks++;
      step();
    end
    bus4.in_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      if (bus4.out_data[31:0] !== 32'h0000_5000 + k) begin
        $display("[TB] FAIL b2b_tail_%0d: got %h expected %h", k, bus4.out_data[31:0], 32'h0000_5000 + k); n_fail++;
      end
      n_checks++;
      step();
    end
    bus4.out_ready = 4'b0000;
    if (bus4.out_valid !== 4'b0000) begin
      $display("[TB] FAIL b2b_drained: got %b expected %b", bus4.out_valid, 4'b0000); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) push4(2'(k), 32'h0000_6000 + k);
    push4(2'd1, 32'h0000_6011);
    bus3.in_valid = 1'b1;
    bus3.in_sel   = 2'd3;
    step();
    bus3.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    if (bus4.out_valid !== 4'b0000 || bus4.out_level !== 12'h000 || bus4.out_data !== 128'h0) begin
      $display("[TB] FAIL rst_mid_async: got valid %b level %h data %h expected all zero",
               bus4.out_valid, bus4.out_level, bus4.out_data); n_fail++;
    end
    n_checks++;
    if (drop_count3 !== 2'd0 || drop_pulse3 !== 1'b0) begin
      $display("[TB] FAIL rst_mid_drop: got count %0d pulse %b expected 0 0", drop_count3, drop_pulse3); n_fail++;
    end
    n_checks++;
    step();
    #3;
    reset = 1'b0;
    step();
    push4(2'd1, 32'h0000_7777);
    if (bus4.out_valid !== 4'b0010 || bus4.out_level !== 12'b000_000_001_000
        || bus4.out_data !== {64'h0, 32'h0000_7777, 32'h0}) begin
      $display("[TB] FAIL rst_mid_after: got valid %b level %b data %h expected 0010 000000001000 7777 on ch1",
               bus4.out_valid, bus4.out_level, bus4.out_data); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_all();
    repeat (2) step();
    test_reset();
    reset = 1'b0;
    step();
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
